mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Main control FSM for the multi-cycle MIPS core. It sequences a shared ALU, one unified instruction/data memory port and the register file across fetch, decode, execute, memory and write-back steps. It decodes the opcode and, for R-type instructions, the funct field, so JR is handled as a native state. It stalls on a memory-ready handshake and flags unsupported opcodes.

## Interface
- No parameters; all encodings are fixed constants in `mips_ctrl_pkg`.
- `clk` in 1: single clock; all state updates occur on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instruction register bits [31:26].
- `funct` in 6: instruction register bits [5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: conditional PC load, qualified by `zero` and `branch_ne`.
- `branch_ne` out 1: 1 selects BNE, 0 selects BEQ.
- `pc_src` out 2: 00 = ALU result, 01 = ALUOut register, 10 = jump target, 11 = reg[rs].
- `i_or_d` out 1: memory address source; 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: instruction register load.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register file controls; `reg_dst` 1 selects rd.
- `alu_src_a` out 1: 0 = PC, 1 = A register.
- `alu_src_b` out 2: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- `alu_op` out 2: 00 = add, 01 = sub, 10 = decode funct.
- `instr_done` out 1: pulses for one cycle in the final state of each instruction.
- `illegal_op` out 1: pulses for one cycle in DECODE when the opcode is unsupported.

## Operation
- Supported opcodes:
  - R-type 000000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - BNE 000101
  - J 000010
  - ADDI 001000
  - JR is R-type with funct 001000.
- States and transitions:
  - FETCH → DECODE when `mem_ready`; otherwise hold in FETCH.
  - DECODE → MEM_ADDR (LW/SW), R_EXEC (R-type, not JR), JR_EXEC, BRANCH (BEQ/BNE), JUMP, ADDI_EXEC, or FETCH (illegal opcode).
  - MEM_ADDR → MEM_READ (LW) or MEM_WRITE (SW).
  - MEM_READ → MEM_WB when `mem_ready`; otherwise hold.
  - MEM_WRITE → FETCH when `mem_ready`; otherwise hold.
  - R_EXEC → R_WB → FETCH.
  - ADDI_EXEC → ADDI_WB → FETCH.
  - MEM_WB, BRANCH, JUMP and JR_EXEC → FETCH.
- Outputs are Moore, decoded from state only. The exceptions are `pc_write` and `ir_write` in FETCH, which are gated by `mem_ready`.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00; `pc_write` = `ir_write` = `mem_ready`.
- DECODE: `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut).
- MEM_ADDR and ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
- MEM_READ: `mem_read`=1, `i_or_d`=1.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
- R_WB: `reg_write`=1, `reg_dst`=1.
- ADDI_WB: `reg_write`=1, `reg_dst`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01; `branch_ne`=1 for BNE.
- JUMP: `pc_write`=1, `pc_src`=10.
- JR_EXEC: `pc_write`=1, `pc_src`=11; no register write.
- Every output not listed for a state is 0.
- `opcode` and `funct` are sampled only in DECODE. Changes in any other state are ignored.

## Timing
- Cycles per instruction with zero wait states:
  - R-type, SW, ADDI: 4
  - LW: 5
  - BEQ, BNE, J, JR: 3
  - Illegal opcode: 2
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- `instr_done` is high in: MEM_WB, MEM_WRITE (on the `mem_ready` cycle), R_WB, ADDI_WB, BRANCH, JUMP and JR_EXEC.
- Reset behaviour:
  - Asserting `reset` at any time forces state to FETCH immediately, including mid-stall or mid-instruction.
  - While in reset: `mem_read`=1, `alu_src_b`=01, and all other outputs are 0 (`pc_write` and `ir_write` are forced to 0 during reset).
  - After reset deasserts, the first rising edge evaluates FETCH normally.
- A `reset` that coincides with `mem_ready` wins; no PC or IR load occurs.

## Structure
- `mips_ctrl_pkg` holds:
  - opcode and funct constants;
  - the state enum (4-bit encoding);
  - `alu_op`, `pc_src` and `alu_src_b` code constants.
- Sub-module `mc_ctrl_decode`: purely combinational map from state, opcode and `mem_ready` to outputs. The top level holds only the state register and next-state logic.

## Test plan
- LW with `mem_ready` low for 2 cycles in MEM_READ → 7 cycles FETCH to FETCH; `reg_write`=1 and `mem_to_reg`=1 in exactly one cycle.
- JR (opcode 000000, funct 001000) → DECODE → JR_EXEC with `pc_write`=1 and `pc_src`=11; `reg_write` stays 0 throughout.
- BNE with `zero`=0 → BRANCH with `pc_write_cond`=1 and `branch_ne`=1; next state FETCH; total 3 cycles.
- Opcode 111111 → `illegal_op` pulses in DECODE; back in FETCH after 2 cycles; no write strobes.
- `reset` asserted during MEM_WRITE stall → FETCH within the same cycle, `mem_write`=0 immediately, and the outputs match the reset values.
- Back-to-back R-type, SW, J, ADDI with `mem_ready`=1 → `instr_done` pulses at cycles 4, 8, 11 and 15.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// opcodes, funct codes, FSM states and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // LW/SW and BEQ/BNE get their own states so the
  // opcode never has to be held past DECODE.
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_LW_ADDR   = 4'd2,
    S_SW_ADDR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_MEM_WB    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BEQ       = 4'd11,
    S_BNE       = 4'd12,
    S_JUMP      = 4'd13,
    S_JR_EXEC   = 4'd14
  } state_t;

  function automatic logic is_legal(
    input logic [5:0] op
  );
    return (op == OP_RTYPE) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ) ||
           (op == OP_BNE)   || (op == OP_J) ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output map: state (+ opcode for illegal_op,
// mem_ready for FETCH loads and SW completion) -> controls.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = SRCB_SHIMM;
        illegal_op = !is_legal(opcode);
      end
      S_LW_ADDR, S_SW_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        branch_ne     = (state == S_BNE);
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        instr_done = 1'b1;
      end
      S_JR_EXEC: begin
        pc_write   = 1'b1;
        pc_src     = PC_RS;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: state
// register + next-state; outputs come from mc_ctrl_decode.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t state, state_nx;
  logic   ready_q;

  // zero qualifies pc_write_cond in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  // Reset beats a coincident mem_ready: no PC/IR load.
  assign ready_q = mem_ready & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:
        if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_nx = (funct == FN_JR) ?
                               S_JR_EXEC : S_R_EXEC;
          OP_LW:    state_nx = S_LW_ADDR;
          OP_SW:    state_nx = S_SW_ADDR;
          OP_BEQ:   state_nx = S_BEQ;
          OP_BNE:   state_nx = S_BNE;
          OP_J:     state_nx = S_JUMP;
          OP_ADDI:  state_nx = S_ADDI_EXEC;
          default:  state_nx = S_FETCH;
        endcase
      end
      S_LW_ADDR:   state_nx = S_MEM_READ;
      S_SW_ADDR:   state_nx = S_MEM_WRITE;
      S_MEM_READ:
        if (mem_ready) state_nx = S_MEM_WB;
      S_MEM_WRITE:
        if (mem_ready) state_nx = S_FETCH;
      S_R_EXEC:    state_nx = S_R_WB;
      S_ADDI_EXEC: state_nx = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB,
      S_BEQ, S_BNE, S_JUMP, S_JR_EXEC:
        state_nx = S_FETCH;
      default:     state_nx = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state         (state),
    .opcode        (opcode),
    .mem_ready     (ready_q),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_src        (pc_src),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: per-instruction expected
// control sequences, table vectors, corner cases, random mix.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_src;
  logic       i_or_d, mem_read, mem_write, ir_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       instr_done, illegal_op;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .branch_ne(branch_ne), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src;
    logic       i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal_op;
  } ctl_t;

  ctl_t got;
  assign got = {pc_write, pc_write_cond, branch_ne, pc_src,
                i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a,
                alu_src_b, alu_op, instr_done, illegal_op};

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int fw;
    int mw;
    int cpi;
    int nrw;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   idle_rand = 1'b1;
  ctl_t exp_q[$];
  bit   rdy_q[$];
  bit   dec_q[$];
  int   done_q[$];

  task automatic check(input string name,
                       input int unsigned act,
                       input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic bit idle();
    return idle_rand ? 1'($urandom) : 1'b1;
  endfunction

  function automatic void push(ctl_t w, bit r, bit d);
    exp_q.push_back(w);
    rdy_q.push_back(r);
    dec_q.push_back(d);
  endfunction

  function automatic ctl_t fetch_w(bit r);
    ctl_t w = '0;
    w.mem_read = 1'b1;
    w.alu_src_b = 2'b01;
    w.pc_write = r;
    w.ir_write = r;
    return w;
  endfunction

  // Expected per-cycle controls of one instruction, given
  // fw FETCH wait cycles and mw data-memory wait cycles.
  function automatic void build(logic [5:0] op,
                                logic [5:0] fn,
                                int fw, int mw);
    ctl_t w;
    bit legal;
    legal = op inside {6'h00, 6'h23, 6'h2b, 6'h04,
                       6'h05, 6'h02, 6'h08};
    exp_q.delete(); rdy_q.delete(); dec_q.delete();
    for (int i = 0; i < fw; i++) push(fetch_w(0), 0, 0);
    push(fetch_w(1), 1, 0);
    w = '0; w.alu_src_b = 2'b11; w.illegal_op = !legal;
    push(w, idle(), 1);
    if (op == 6'h00 && fn == 6'h08) begin
      w = '0; w.pc_write = 1; w.pc_src = 2'b11;
      w.instr_done = 1; push(w, idle(), 0);
    end else if (op == 6'h00) begin
      w = '0; w.alu_src_a = 1; w.alu_op = 2'b10;
      push(w, idle(), 0);
      w = '0; w.reg_write = 1; w.reg_dst = 1;
      w.instr_done = 1; push(w, idle(), 0);
    end else if (op == 6'h23 || op == 6'h2b) begin
      w = '0; w.alu_src_a = 1; w.alu_src_b = 2'b10;
      push(w, idle(), 0);
      w = '0; w.i_or_d = 1;
      if (op == 6'h23) w.mem_read = 1;
      else w.mem_write = 1;
      for (int i = 0; i < mw; i++) push(w, 0, 0);
      if (op == 6'h2b) w.instr_done = 1;
      push(w, 1, 0);
      if (op == 6'h23) begin
        w = '0; w.reg_write = 1; w.mem_to_reg = 1;
        w.instr_done = 1; push(w, idle(), 0);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      w = '0; w.alu_src_a = 1; w.alu_op = 2'b01;
      w.pc_write_cond = 1; w.pc_src = 2'b01;
      w.branch_ne = (op == 6'h05); w.instr_done = 1;
      push(w, idle(), 0);
    end else if (op == 6'h02) begin
      w = '0; w.pc_write = 1; w.pc_src = 2'b10;
      w.instr_done = 1; push(w, idle(), 0);
    end else if (op == 6'h08) begin
      w = '0; w.alu_src_a = 1; w.alu_src_b = 2'b10;
      push(w, idle(), 0);
      w = '0; w.reg_write = 1; w.instr_done = 1;
      push(w, idle(), 0);
    end
  endfunction

  // Plays n cycles of the built sequence; opcode/funct
  // are garbage everywhere except the DECODE cycle.
  task automatic play(input logic [5:0] op,
                      input logic [5:0] fn, input int n,
                      output int cpi, output int nrw);
    cpi = 0;
    nrw = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_ready = rdy_q[i];
      zero = 1'($urandom);
      if (dec_q[i]) begin
        opcode = op; funct = fn;
      end else begin
        opcode = 6'($urandom); funct = 6'($urandom);
      end
      #1;
      cyc++;
      check($sformatf("op%02h_cyc%0d", op, i + 1),
            got, exp_q[i]);
      if (cpi == 0 && (got.instr_done || got.illegal_op))
        cpi = i + 1;
      if (got.instr_done) done_q.push_back(cyc);
      nrw += int'(got.reg_write);
    end
  endtask

  task automatic run(input logic [5:0] op,
                     input logic [5:0] fn,
                     input int fw, input int mw,
                     output int cpi, output int nrw);
    build(op, fn, fw, mw);
    play(op, fn, exp_q.size(), cpi, nrw);
  endtask

  initial begin
    vec_t tbl[12];
    int   cpi, nrw, base;
    int   exp_done[4];
    logic [5:0] ops[8];
    logic [5:0] op, fn;

    tbl[0]  = '{6'h00, 6'h20, 0, 0, 4, 1};
    tbl[1]  = '{6'h00, 6'h08, 0, 0, 3, 0};
    tbl[2]  = '{6'h23, 6'h00, 0, 2, 7, 1};
    tbl[3]  = '{6'h23, 6'h11, 0, 0, 5, 1};
    tbl[4]  = '{6'h2b, 6'h00, 0, 0, 4, 0};
    tbl[5]  = '{6'h2b, 6'h00, 1, 2, 7, 0};
    tbl[6]  = '{6'h04, 6'h00, 0, 0, 3, 0};
    tbl[7]  = '{6'h05, 6'h00, 0, 0, 3, 0};
    tbl[8]  = '{6'h02, 6'h00, 0, 0, 3, 0};
    tbl[9]  = '{6'h08, 6'h08, 0, 0, 4, 1};
    tbl[10] = '{6'h3f, 6'h00, 0, 0, 2, 0};
    tbl[11] = '{6'h00, 6'h22, 3, 0, 7, 1};
    exp_done = '{4, 8, 11, 15};
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04,
            6'h05, 6'h02, 6'h08, 6'h3f};

    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    repeat (2) begin
      @(negedge clk); #1;
      check("reset_outputs", got, fetch_w(0));
    end
    reset = 1'b0; mem_ready = 1'b0;

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].fn, tbl[i].fw, tbl[i].mw,
          cpi, nrw);
      check($sformatf("vec%0d_cycles", i), cpi, tbl[i].cpi);
      check($sformatf("vec%0d_regwr", i), nrw, tbl[i].nrw);
    end

    // Reset in the middle of a stalled SW, with mem_ready
    // high so a stray PC/IR load would show.
    build(6'h2b, 6'h00, 0, 5);
    play(6'h2b, 6'h00, 4, cpi, nrw);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("rst_stall_mem_write", mem_write, 0);
    check("rst_stall_outputs", got, fetch_w(0));
    @(negedge clk); #1;
    check("rst_hold_outputs", got, fetch_w(0));
    reset = 1'b0; mem_ready = 1'b0;
    run(6'h00, 6'h25, 0, 0, cpi, nrw);
    check("after_rst_cycles", cpi, 4);

    idle_rand = 1'b0;
    done_q.delete();
    base = cyc;
    run(6'h00, 6'h20, 0, 0, cpi, nrw);
    run(6'h2b, 6'h00, 0, 0, cpi, nrw);
    run(6'h02, 6'h00, 0, 0, cpi, nrw);
    run(6'h08, 6'h00, 0, 0, cpi, nrw);
    check("b2b_done_count", done_q.size(), 4);
    if (done_q.size() == 4)
      foreach (exp_done[k])
        check($sformatf("b2b_done%0d", k),
              done_q[k] - base, exp_done[k]);
    idle_rand = 1'b1;

    for (int n = 0; n < 200; n++) begin
      op = ops[$urandom_range(7)];
      if (op == 6'h3f) op = 6'($urandom);
      fn = ($urandom_range(3) == 0) ? 6'h08 : 6'($urandom);
      run(op, fn, $urandom_range(3), $urandom_range(3),
          cpi, nrw);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
